// File: rtl/bin2bcd_disp_feeder_pkg.sv
// Shared types and helpers for the binary-to-BCD display feeder.
// Optional feature macro used by this slice: DISP_HEX_BYPASS_EN.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } disp_state_t;

  localparam logic [3:0] BCD_NINE = 4'h9;

  // Number of decimal digits needed to hold any w-bit binary value.
  function automatic int bcd_digits(input int w);
    return (w * 301) / 1000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_disp_feeder_if.sv
// Write/result bus between the CPU output port and the BCD feeder.
// With DISP_HEX_BYPASS_EN defined the bus also carries hex_mode.
interface bin2bcd_disp_feeder_if #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 4
);

  logic                  wr_en;
  logic [IN_W-1:0]       wr_data;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;
`ifdef DISP_HEX_BYPASS_EN
  logic                  hex_mode;
`endif

`ifdef DISP_HEX_BYPASS_EN
  modport master (output wr_en, output wr_data, output hex_mode,
                  input busy, input done, input bcd_out, input ovf);
  modport slave  (input wr_en, input wr_data, input hex_mode,
                  output busy, output done, output bcd_out, output ovf);
`else
  modport master (output wr_en, output wr_data,
                  input busy, input done, input bcd_out, input ovf);
  modport slave  (input wr_en, input wr_data,
                  output busy, output done, output bcd_out, output ovf);
`endif

endinterface

// File: rtl/bin2bcd_disp_feeder_dd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
module dd_digit_adj (
  input  logic [3:0] dig,
  output logic [3:0] adj
);

  // Add 3 when the digit would exceed 9 after doubling.
  always_comb begin
    adj = dig;
    if (dig >= 4'd5) begin
      adj = dig + 4'd3;
    end else begin
      adj = dig;
    end
  end

endmodule

// File: rtl/bin2bcd_disp_feeder.sv
// Sequential binary-to-BCD converter feeding the 4-digit seven-segment
// driver. One shift per clock; results above 10^DIGITS-1 saturate to all
// nines with ovf set. Optional macro: DISP_HEX_BYPASS_EN (raw hex write).
module bin2bcd_disp_feeder
  import disp_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bin2bcd_disp_feeder_if.slave  bus
);

  // The accumulator always keeps at least one digit above the displayed
  // ones so that saturation can be detected from the upper digits alone.
  localparam int DIG_INT = bcd_digits(IN_W);
  localparam int ACC_D   = (DIG_INT > DIGITS) ? DIG_INT : DIGITS + 1;
  localparam int ACC_W   = 4 * ACC_D;
  localparam int OUT_W   = 4 * DIGITS;
  localparam int CNT_W   = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  disp_state_t        state_r, state_s;
  logic [IN_W-1:0]    sreg_r, sreg_s;
  logic [ACC_W-1:0]   acc_r, acc_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [OUT_W-1:0]   bcd_r, bcd_s;
  logic               ovf_r, ovf_s;

  logic [ACC_W-1:0]   acc_adj_s;
  logic [ACC_W-1:0]   acc_shift_s;
  logic [IN_W-1:0]    sreg_shift_s;
  logic [OUT_W-1:0]   bcd_fin_s;
  logic               ovf_fin_s;

  // Per-digit add-3 correction ahead of each shift.
  for (genvar g = 0; g < ACC_D; g++) begin : g_adj
    dd_digit_adj u_adj (
      .dig (acc_r[4*g +: 4]),
      .adj (acc_adj_s[4*g +: 4])
    );
  end

  assign acc_shift_s  = {acc_adj_s[ACC_W-2:0], sreg_r[IN_W-1]};
  assign sreg_shift_s = {sreg_r[IN_W-2:0], 1'b0};

  // Saturate the post-shift accumulator when any hidden upper digit is set.
  always_comb begin
    bcd_fin_s = acc_shift_s[OUT_W-1:0];
    ovf_fin_s = 1'b0;
    if (acc_shift_s[ACC_W-1:OUT_W] != {(ACC_W-OUT_W){1'b0}}) begin
      bcd_fin_s = {DIGITS{BCD_NINE}};
      ovf_fin_s = 1'b1;
    end else begin
      bcd_fin_s = acc_shift_s[OUT_W-1:0];
      ovf_fin_s = 1'b0;
    end
  end

  // Next-state and next-output logic; done is a single-cycle pulse.
  always_comb begin
    state_s = state_r;
    sreg_s  = sreg_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    bcd_s   = bcd_r;
    ovf_s   = ovf_r;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (bus.wr_en) begin
`ifdef DISP_HEX_BYPASS_EN
          if (bus.hex_mode) begin
            bcd_s  = OUT_W'(bus.wr_data);
            ovf_s  = 1'b0;
            done_s = 1'b1;
          end else begin
            sreg_s  = bus.wr_data;
            acc_s   = {ACC_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
            busy_s  = 1'b1;
            state_s = SHIFT;
          end
`else
          sreg_s  = bus.wr_data;
          acc_s   = {ACC_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          busy_s  = 1'b1;
          state_s = SHIFT;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        sreg_s = sreg_shift_s;
        acc_s  = acc_shift_s;
        if (cnt_r == LAST_CNT) begin
          cnt_s   = {CNT_W{1'b0}};
          bcd_s   = bcd_fin_s;
          ovf_s   = ovf_fin_s;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          busy_s  = 1'b1;
          state_s = SHIFT;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      sreg_r  <= {IN_W{1'b0}};
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bcd_r   <= {OUT_W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      sreg_r  <= sreg_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      bcd_r   <= bcd_s;
      ovf_r   <= ovf_s;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.bcd_out = bcd_r;
  assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_bin2bcd_disp_feeder.sv
// Directed plus randomized bench for bin2bcd_disp_feeder against a decimal
// arithmetic reference model.
module tb_bin2bcd_disp_feeder;
  import disp_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [15:0] cur_bcd;
  logic        cur_ovf;

  bin2bcd_disp_feeder_if #(.IN_W(16), .DIGITS(4)) bus ();

  bin2bcd_disp_feeder #(.IN_W(16), .DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: saturated decimal digits of v, with overflow flag on top.
  function automatic logic [16:0] ref_conv(input int v);
    logic [15:0] b;
    if (v > 9999) begin
      return {1'b1, 16'h9999};
    end
    b[15:12] = 4'((v / 1000) % 10);
    b[11:8]  = 4'((v / 100) % 10);
    b[7:4]   = 4'((v / 10) % 10);
    b[3:0]   = 4'(v % 10);
    return {1'b0, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a write on the current negedge; returns at the negedge after the accept edge.
  task automatic start(input logic [15:0] v, input string tag);
    bus.wr_data = v;
    bus.wr_en   = 1'b1;
`ifdef DISP_HEX_BYPASS_EN
    bus.hex_mode = 1'b0;
`endif
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    @(negedge clk);
    check({tag, "/busy_hi"}, 32'(bus.busy), 32'd1);
    check({tag, "/done_lo"}, 32'(bus.done), 32'd0);
    check({tag, "/bcd_hold"}, 32'(bus.bcd_out), 32'(cur_bcd));
    check({tag, "/ovf_hold"}, 32'(bus.ovf), 32'(cur_ovf));
  endtask

  // Wait for done and check result and latency; optional dropped write at negedge drop_at.
  task automatic finish(input int v, input string tag, input int drop_at, input logic [15:0] drop_v);
    logic [16:0] exp;
    int k;
    bit seen;
    exp  = ref_conv(v);
    seen = 1'b0;
    k    = 1;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      bus.wr_en = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (k == 8) check({tag, "/mid_bcd"}, 32'(bus.bcd_out), 32'(cur_bcd));
        if (k == 16) check({tag, "/busy_last"}, 32'(bus.busy), 32'd1);
        if (k == drop_at) begin
          bus.wr_data = drop_v;
          bus.wr_en   = 1'b1;
        end
      end
    end
    check({tag, "/latency"}, 32'(k), 32'd17);
    check({tag, "/busy_lo"}, 32'(bus.busy), 32'd0);
    check({tag, "/bcd"}, 32'(bus.bcd_out), 32'(exp[15:0]));
    check({tag, "/ovf"}, 32'(bus.ovf), 32'(exp[16]));
    cur_bcd = exp[15:0];
    cur_ovf = exp[16];
  endtask

  // Idle for n cycles expecting no activity and stable outputs.
  task automatic quiet(input int n, input string tag);
    int nd, nb, nc;
    nd = 0; nb = 0; nc = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) nd++;
      if (bus.busy) nb++;
      if (bus.bcd_out !== cur_bcd || bus.ovf !== cur_ovf) nc++;
    end
    check({tag, "/no_done"}, 32'(nd), 32'd0);
    check({tag, "/no_busy"}, 32'(nb), 32'd0);
    check({tag, "/stable"}, 32'(nc), 32'd0);
  endtask

  initial begin
    int v;
    n_cmp = 0;
    n_err = 0;
    cur_bcd = 16'h0000;
    cur_ovf = 1'b0;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 16'h0000;
`ifdef DISP_HEX_BYPASS_EN
    bus.hex_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset/busy", 32'(bus.busy), 32'd0);
    check("reset/done", 32'(bus.done), 32'd0);
    check("reset/bcd", 32'(bus.bcd_out), 32'd0);
    check("reset/ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic conversions, chained so each write lands while done is high.
    start(16'd1234, "t1234");  finish(1234, "t1234", 0, 16'd0);
    start(16'd9999, "t9999");  finish(9999, "t9999", 0, 16'd0);
    start(16'd0, "t0");        finish(0, "t0", 0, 16'd0);
    start(16'd10000, "t10000"); finish(10000, "t10000", 0, 16'd0);
    start(16'd42, "t42");      finish(42, "t42", 0, 16'd0);

    // Saturation with a write attempted mid-conversion that must be dropped.
    start(16'd65535, "t65535"); finish(65535, "t65535", 5, 16'd7);
    quiet(20, "drop");

    // Reset in the middle of a conversion.
    start(16'd500, "t500a");
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst/busy", 32'(bus.busy), 32'd0);
    check("midrst/done", 32'(bus.done), 32'd0);
    check("midrst/bcd", 32'(bus.bcd_out), 32'd0);
    check("midrst/ovf", 32'(bus.ovf), 32'd0);
    cur_bcd = 16'h0000;
    cur_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    quiet(25, "midrst");
    start(16'd500, "t500b");   finish(500, "t500b", 0, 16'd0);

    // Randomized values, biased toward the saturation boundary.
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) v = int'($urandom_range(9990, 10010));
      else v = int'($urandom_range(0, 65535));
      start(16'(v), "rand");
      finish(v, "rand", 0, 16'd0);
    end

`ifdef DISP_HEX_BYPASS_EN
    // Raw hex write bypasses conversion and never raises busy.
    @(negedge clk);
    bus.wr_data  = 16'hBEEF;
    bus.hex_mode = 1'b1;
    bus.wr_en    = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_en    = 1'b0;
    bus.hex_mode = 1'b0;
    @(negedge clk);
    check("hex/bcd", 32'(bus.bcd_out), 32'h0000BEEF);
    check("hex/done", 32'(bus.done), 32'd1);
    check("hex/busy", 32'(bus.busy), 32'd0);
    check("hex/ovf", 32'(bus.ovf), 32'd0);
    cur_bcd = 16'hBEEF;
    cur_ovf = 1'b0;
    @(negedge clk);
    check("hex/done_lo", 32'(bus.done), 32'd0);
    check("hex/busy_lo", 32'(bus.busy), 32'd0);
    start(16'h1234, "hexconv"); finish(4660, "hexconv", 0, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
